// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch queue.
//   fetch_entry_t : default-width (32-bit) queue entry {pc, instr}
//   BR_ABS/BR_REL : branch-target modes (absolute offset / PC-relative)
//   PC_STEP       : byte increment between sequential fetches
package if_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    localparam int unsigned BR_ABS  = 0;
    localparam int unsigned BR_REL  = 1;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO holding fetched entries.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write an entry (ignored when full without a pop)
//   i_pop          : retire the head entry (ignored when empty)
//   i_flush        : discard all entries; wins over push/pop
//   o_head         : head entry, read straight from the storage registers
//   o_valid        : head entry present
//   o_count        : number of stored entries (0..Q_DEPTH)
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned Q_DEPTH = 4,
    parameter type         T       = fetch_entry_t
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  T                         i_data,
    output T                         o_head,
    output logic                     o_valid,
    output logic [$clog2(Q_DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(Q_DEPTH);
    localparam int unsigned CW = AW + 1;

    T                r_mem [Q_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_en;
    logic            w_rd_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(Q_DEPTH));
    assign w_rd_en = i_pop && !w_empty;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // where the write pointer sits.
    assign w_wr_en = i_push && (!w_full || w_rd_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_rd_en};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a prefetch queue and redirect.
//   clk, rst            : clock, asynchronous active-low reset
//   brTaken             : redirect from EX (wins over freeze and pop)
//   brOffset, brPC      : target = BR_MODE ? brPC + brOffset : brOffset
//   freeze              : hazard stall (no issue, no pop)
//   imem_req/imem_addr  : synchronous instruction-memory read port
//   imem_rdata          : read data, one cycle after imem_req
//   out_valid/out_ready : handshake toward decode
//   PC, instruction     : head entry (0 while out_valid is low)
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    IMEM_AW  = 8,
    parameter int unsigned    Q_DEPTH  = 4,
    parameter int unsigned    BR_MODE  = BR_REL,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               brTaken,
    input  logic [XLEN-1:0]    brOffset,
    input  logic [XLEN-1:0]    brPC,
    input  logic               freeze,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    instruction
);

    localparam int unsigned CW = $clog2(Q_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_issued_pc;
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_issue;
    logic            w_kill;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    entry_t          w_push_data;
    entry_t          w_head;

    // Credit check counts the outstanding response, so every response
    // is guaranteed a free slot when it arrives.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = rst && !freeze && !brTaken
                         && (w_occupancy < (CW+1)'(Q_DEPTH));

    assign w_target_raw = (BR_MODE == BR_REL) ? (brPC + brOffset) : brOffset;
    assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};

    // A response can only be outstanding for one cycle, so it arrives in
    // the very cycle a redirect is raised; killing it is a same-cycle drop.
    assign w_kill = brTaken;
    assign w_push = r_inflight && !w_kill;
    assign w_pop  = w_valid && out_ready && !freeze && !brTaken;

    assign w_push_data.pc    = r_issued_pc;
    assign w_push_data.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc       <= RESET_PC;
            r_issued_pc <= '0;
            r_inflight  <= 1'b0;
        end else if (brTaken) begin
            r_fpc      <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issued_pc <= r_fpc;
                r_fpc       <= r_fpc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .Q_DEPTH (Q_DEPTH),
        .T       (entry_t)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (brTaken),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign imem_req    = w_issue;
    assign imem_addr   = r_fpc[IMEM_AW+1:2];
    assign out_valid   = w_valid;
    assign PC          = w_valid ? w_head.pc    : '0;
    assign instruction = w_valid ? w_head.instr : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: two instances (BR_MODE=0 and BR_MODE=1) share
// all inputs; each is compared every cycle against a queue-based model.
module tb_if_fetch_queue;

    localparam int D = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, brTaken, freeze, out_ready;
    logic [31:0] brOffset, brPC;

    logic        req_w   [2];
    logic [7:0]  addr_w  [2];
    logic [31:0] rdata_w [2];
    logic        valid_w [2];
    logic [31:0] pc_w    [2];
    logic [31:0] ins_w   [2];

    logic [31:0] mem [256];

    // Instruction memory: one-cycle synchronous read per instance.
    always @(posedge clk) begin
        if (req_w[0]) rdata_w[0] <= mem[addr_w[0]];
        if (req_w[1]) rdata_w[1] <= mem[addr_w[1]];
    end

    if_fetch_queue #(.XLEN(32), .IMEM_AW(8), .Q_DEPTH(4), .BR_MODE(0), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst), .brTaken(brTaken), .brOffset(brOffset), .brPC(brPC),
        .freeze(freeze), .imem_req(req_w[0]), .imem_addr(addr_w[0]), .imem_rdata(rdata_w[0]),
        .out_valid(valid_w[0]), .out_ready(out_ready), .PC(pc_w[0]), .instruction(ins_w[0]));

    if_fetch_queue #(.XLEN(32), .IMEM_AW(8), .Q_DEPTH(4), .BR_MODE(1), .RESET_PC(32'h0)) dut1 (
        .clk(clk), .rst(rst), .brTaken(brTaken), .brOffset(brOffset), .brPC(brPC),
        .freeze(freeze), .imem_req(req_w[1]), .imem_addr(addr_w[1]), .imem_rdata(rdata_w[1]),
        .out_valid(valid_w[1]), .out_ready(out_ready), .PC(pc_w[1]), .instruction(ins_w[1]));

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of PCs delivered to decode, one pending fetch,
    // next fetch PC. Instruction of an entry is mem[pc / 4 mod 256].
    logic [31:0] mq [2][$];
    bit          mpend    [2];
    logic [31:0] mpend_pc [2];
    logic [31:0] mfpc     [2];

    function automatic logic exp_req(input int m);
        return rst && !freeze && !brTaken && ((mq[m].size() + (mpend[m] ? 1 : 0)) < D);
    endfunction

    function automatic logic [73:0] exp_bundle(input int m);
        logic        v;
        logic [31:0] p, ins, f;
        v = (mq[m].size() > 0);
        p = 32'h0;
        ins = 32'h0;
        if (v) begin
            p   = mq[m][0];
            ins = mem[p[9:2]];
        end
        f = mfpc[m];
        return {v, p, ins, exp_req(m), f[9:2]};
    endfunction

    function automatic logic [73:0] obs(input int m);
        return {valid_w[m], pc_w[m], ins_w[m], req_w[m], addr_w[m]};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mpend[m]    = 1'b0;
            mpend_pc[m] = 32'h0;
            mfpc[m]     = 32'h0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic        iss, pp;
            logic [31:0] tgt;
            if (!rst) begin
                mq[m].delete();
                mpend[m] = 1'b0;
                mfpc[m]  = 32'h0;
            end else begin
                iss = exp_req(m);
                pp  = (mq[m].size() > 0) && out_ready && !freeze;
                if (brTaken) begin
                    tgt = (m == 1) ? (brPC + brOffset) : brOffset;
                    tgt[1:0] = 2'b00;
                    mq[m].delete();
                    mpend[m] = 1'b0;
                    mfpc[m]  = tgt;
                end else begin
                    if (pp) void'(mq[m].pop_front());
                    if (mpend[m]) mq[m].push_back(mpend_pc[m]);
                    mpend[m] = iss;
                    if (iss) begin
                        mpend_pc[m] = mfpc[m];
                        mfpc[m]     = mfpc[m] + 32'd4;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        brTaken = 0; freeze = 0; out_ready = 0; brOffset = '0; brPC = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        model_reset();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL reset dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            checks++;
            if ({valid_w[1], pc_w[1], ins_w[1], req_w[1], addr_w[1]} !== 74'h0) begin
                failures++;
                $display("FAIL reset_zero c%0d: got %h exp 0", c, obs(1));
            end
            tick();
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL stream dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            checks++;
            if (addr_w[1] !== 8'(c) || req_w[1] !== 1'b1) begin
                failures++;
                $display("FAIL stream_addr c%0d: got %0d req %b exp %0d req 1", c, addr_w[1], req_w[1], c);
            end
            if (c >= 2) begin
                checks++;
                if (valid_w[1] !== 1'b1 || pc_w[1] !== 32'(4 * (c - 2)) || ins_w[1] !== 32'(c - 2)) begin
                    failures++;
                    $display("FAIL stream_out c%0d: got v%b pc %h ins %h exp v1 pc %h ins %h",
                             c, valid_w[1], pc_w[1], ins_w[1], 32'(4 * (c - 2)), 32'(c - 2));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] popped [$];
        do_reset();
        out_ready = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL stall dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            tick();
        end
        #2;
        checks++;
        if (req_w[1] !== 1'b0 || valid_w[1] !== 1'b1 || pc_w[1] !== 32'h0) begin
            failures++;
            $display("FAIL stall_full: got req %b v %b pc %h exp req 0 v 1 pc 0", req_w[1], valid_w[1], pc_w[1]);
        end
        out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL drain dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            if (valid_w[1] === 1'b1) popped.push_back(pc_w[1]);
            tick();
        end
        checks++;
        if (popped.size() != 8) begin
            failures++;
            $display("FAIL drain_count: got %0d exp 8", popped.size());
        end
        for (int k = 0; k < popped.size() && k < 8; k++) begin
            checks++;
            if (popped[k] !== 32'(4 * k)) begin
                failures++;
                $display("FAIL drain_order k%0d: got %h exp %h", k, popped[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_rel();
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 11; c++) begin
            brTaken  = (c == 5);
            brPC     = 32'h10;
            brOffset = 32'h20;
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL redirect dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (valid_w[1] !== 1'b0 || (c == 6 && addr_w[1] !== 8'h0C)) begin
                    failures++;
                    $display("FAIL redirect_gap c%0d: got v %b addr %h exp v 0 addr 0c", c, valid_w[1], addr_w[1]);
                end
            end
            if (c == 8) begin
                checks++;
                if (valid_w[1] !== 1'b1 || pc_w[1] !== 32'h30) begin
                    failures++;
                    $display("FAIL redirect_first: got v %b pc %h exp v 1 pc 30", valid_w[1], pc_w[1]);
                end
            end
            tick();
        end
        brTaken = 0;
    endtask

    task automatic test_abs_freeze();
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            brTaken  = (c == 4);
            freeze   = (c == 4);
            brPC     = 32'h0;
            brOffset = 32'h3FF;
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL absfrz dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            if (c == 5) begin
                checks++;
                if (addr_w[0] !== 8'hFF || req_w[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL abs_target: got addr %h req %b exp ff req 1", addr_w[0], req_w[0]);
                end
            end
            if (c == 6) begin
                checks++;
                if (addr_w[0] !== 8'h00) begin
                    failures++;
                    $display("FAIL abs_wrap: got addr %h exp 00", addr_w[0]);
                end
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (valid_w[0] !== 1'b1 || pc_w[0] !== ((c == 7) ? 32'h3FC : 32'h400)
                    || (c == 8 && ins_w[0] !== 32'h0)) begin
                    failures++;
                    $display("FAIL abs_out c%0d: got v %b pc %h ins %h", c, valid_w[0], pc_w[0], ins_w[0]);
                end
            end
            tick();
        end
        brTaken = 0;
        freeze  = 0;
    endtask

    task automatic test_freeze();
        logic [31:0] hp, hi;
        hp = '0;
        hi = '0;
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 9; c++) begin
            freeze = (c >= 3 && c <= 5);
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL freeze dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            if (c == 3) begin
                hp = pc_w[1];
                hi = ins_w[1];
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (valid_w[1] !== 1'b1 || pc_w[1] !== hp || ins_w[1] !== hi || hp !== 32'h4
                    || (c <= 5 && req_w[1] !== 1'b0)) begin
                    failures++;
                    $display("FAIL freeze_hold c%0d: got v %b pc %h ins %h req %b exp v 1 pc %h ins %h",
                             c, valid_w[1], pc_w[1], ins_w[1], req_w[1], 32'h4, hi);
                end
            end
            tick();
        end
        freeze = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 6; c++) begin
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL prerst dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            tick();
        end
        #3;
        rst = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_w[m] !== 1'b0 || req_w[m] !== 1'b0 || pc_w[m] !== 32'h0
                || ins_w[m] !== 32'h0 || addr_w[m] !== 8'h0) begin
                failures++;
                $display("FAIL async_rst dut%0d: got %h exp 0", m, obs(m));
            end
        end
        model_reset();
        tick();
        rst = 1;
        for (int c = 0; c < 6; c++) begin
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL postrst dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            if (c == 0 || c == 2) begin
                checks++;
                if ((c == 0 && (req_w[1] !== 1'b1 || addr_w[1] !== 8'h0))
                    || (c == 2 && (valid_w[1] !== 1'b1 || pc_w[1] !== 32'h0))) begin
                    failures++;
                    $display("FAIL restart c%0d: got %h", c, obs(1));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        rst = 0;
        idle_inputs();
        model_reset();
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        tick();
        rst = 1;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            freeze    = ($urandom_range(0, 9) == 0);
            brTaken   = ($urandom_range(0, 19) == 0);
            brPC      = $urandom;
            brOffset  = $urandom;
            #2;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_bundle(m)) begin
                    failures++;
                    $display("FAIL random dut%0d c%0d: got %h exp %h", m, c, obs(m), exp_bundle(m));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'(k);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_rel();
        test_abs_freeze();
        test_freeze();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue and branch redirect. Successor to the single-register IF stage: keeps the `brTaken`/`brOffset`/`freeze` control semantics, adds a synchronous instruction-memory port, a PC+instruction FIFO, a valid/ready handshake to decode, and a selectable branch-target mode. It sits between the instruction memory and the IF/ID boundary.

## Interface
- `XLEN`, default 32: PC and instruction width.
- `IMEM_AW`, default 8: instruction-memory word-address width, giving 256 words.
- `Q_DEPTH`, default 4: prefetch queue entries. Must be a power of two, at least 2.
- `BR_MODE`, default 1: 0 means target = `brOffset` (absolute); 1 means target = `brPC + brOffset`.
- `RESET_PC`, default 0: first fetch address.
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `brTaken`  in  1: redirect request from EX.
- `brOffset`  in  XLEN: branch offset, or absolute target when `BR_MODE=0`.
- `brPC`  in  XLEN: PC of the branch. Used only when `BR_MODE=1`.
- `freeze`  in  1: hazard stall.
- `imem_req`  out  1: read strobe.
- `imem_addr`  out  IMEM_AW: word address, equal to `fpc[IMEM_AW+1:2]`.
- `imem_rdata`  in  XLEN: read data, valid exactly 1 cycle after `imem_req`.
- `out_valid`  out  1: head entry presented to decode.
- `out_ready`  in  1: decode accepts the head entry.
- `PC`  out  XLEN: PC of the head entry.
- `instruction`  out  XLEN: instruction of the head entry.

## Operation
- Reset (`rst=0`, asynchronous):
  - `fpc` = `RESET_PC`.
  - Queue empty; in-flight flag cleared.
  - Outputs: `imem_req=0`, `imem_addr=RESET_PC[IMEM_AW+1:2]`, `out_valid=0`, `PC=0`, `instruction=0`.
- Issue: `imem_req=1` when all of the following hold:
  - `freeze=0`;
  - `brTaken=0`;
  - `count + inflight` is below `Q_DEPTH`. This is credit-based, so a response always has a free slot.
- When a request issues, `fpc <= fpc + 4` (mod 2^XLEN).
- The memory index wraps naturally because only `fpc[IMEM_AW+1:2]` is used.
- Capture: in the cycle after an issue, `{fpc_issued, imem_rdata}` is pushed, unless it has been killed by a redirect.
- Dequeue: a pop occurs when `out_valid && out_ready && !freeze`. Push and pop may happen in the same cycle, including when the queue is full or empty.
- While `out_valid=0`, `PC` and `instruction` read 0.
- Freeze:
  - No new issue and no pop. The head entry stays stable.
  - A response already in flight is still captured, because its credit was reserved.
- Redirect (`brTaken=1`):
  - Target = `BR_MODE ? brPC + brOffset : brOffset`, with bits `[1:0]` forced to 0.
  - On that edge: `fpc <= target`, queue flushed, in-flight response marked killed and dropped on arrival.
  - Redirect takes priority over `freeze` and over a same-cycle pop. That pop does not occur, and `out_valid` is 0 in the following cycle.
- A redirect asserted on consecutive cycles: the last one wins. Each assertion flushes again.

## Timing
- Fetch latency: request in cycle t; data pushed at the end of t+1; `out_valid=1` with that entry in t+2.
- Redirect in cycle t: first request to the target in t+1; `out_valid` for the target in t+3.
- Steady state, with `out_ready=1` and no freeze: one instruction per cycle.
- Release of `rst` mid-operation: the first request issues in the first cycle `rst=1`, at `RESET_PC`.
- The handshake follows AXI-stream rules:
  - `PC` and `instruction` are stable while `out_valid=1` and `out_ready=0`.
  - `out_valid` never drops without a pop, a redirect or a reset.

## Structure
- Package `if_pkg` holds:
  - `fetch_entry_t` struct {`pc`, `instr`};
  - `BR_ABS=0` and `BR_REL=1` constants;
  - a `PC_STEP=4` constant.
- Sub-module `fetch_fifo`:
  - parametrised on `Q_DEPTH` and entry type;
  - synchronous push/pop, `flush` input, `count` output, registered head.
- The top level holds `fpc`, the in-flight/kill flags, credit logic and target arithmetic.

## Test plan
- Reset, then `out_ready=1` with `imem[k]=k`: `imem_addr` runs 0,1,2,…; from cycle 2, `PC`=0,4,8,… and `instruction`=0,1,2,… every cycle.
- `out_ready=0` for 10 cycles: exactly `Q_DEPTH` (4) entries queue up and `imem_req` deasserts. On release, entries PC=0..12 drain in order with no duplicate and no loss.
- `BR_MODE=1`, `brPC=0x10`, `brOffset=0x20`, in cycle 5: queue flushed, the killed in-flight response is not seen, next `imem_addr=0x0C`, and the first valid `PC=0x30` three cycles later.
- `BR_MODE=0`, `brOffset=0x3FF` during `freeze=1`: redirect still taken, target 0x3FC, `imem_addr=0xFF`. The next fetch wraps to address 0x00, with `PC=0x400`.
- `freeze=1` for 3 cycles with one request in flight: the response is captured, `count` rises by 1, the head `PC`/`instruction` stay constant, and there are no pops.
- Assert `rst=0` mid-stream, asynchronously between edges: `out_valid`, `imem_req`, `PC` and `instruction` go to 0 immediately. After release, fetching restarts at `RESET_PC`.
